// File: rtl/regbank_initiator_if.sv
// regbank_initiator_if: request/response handshakes plus the register-bank trigger side
interface regbank_initiator_if;
    logic        rd_valid;
    logic        rd_ready;
    logic [3:0]  rd_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        triggerOutr;
    logic [3:0]  addrr;
    logic        readyIn;
    logic [31:0] dataIn;
    logic        triggerOutw;
    logic [3:0]  addrw;
    logic [31:0] dataOut;
    modport master (
        input  rd_valid, rd_addr, rsp_ready, wr_valid, wr_addr, wr_data, readyIn, dataIn,
        output rd_ready, rsp_valid, rsp_data, rsp_err, wr_ready, triggerOutr, addrr,
               triggerOutw, addrw, dataOut
    );
    modport slave (
        output rd_valid, rd_addr, rsp_ready, wr_valid, wr_addr, wr_data, readyIn, dataIn,
        input  rd_ready, rsp_valid, rsp_data, rsp_err, wr_ready, triggerOutr, addrr,
               triggerOutw, addrw, dataOut
    );
endinterface

// File: rtl/regbank_initiator.sv
// regbank_initiator: turns valid/ready register reads/writes into two-phase bank trigger toggles
module regbank_initiator #(
    parameter int WR_HOLD    = 2,
    parameter int RD_WAIT    = 4,
    parameter int RD_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    regbank_initiator_if.master        bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_SETUP = 3'd1;
    localparam logic [2:0] S_WR_HOLD  = 3'd2;
    localparam logic [2:0] S_RD_SETUP = 3'd3;
    localparam logic [2:0] S_RD_WAIT  = 3'd4;
    localparam logic [2:0] S_RD_DONE  = 3'd5;
    localparam logic [2:0] S_RSP      = 3'd6;
    localparam logic [4:0] WR_HOLD_C  = 5'(WR_HOLD);
    localparam logic [4:0] RD_WAIT_C  = 5'(RD_WAIT);
    localparam logic [4:0] RD_TO_C    = 5'(RD_TIMEOUT);

    logic [2:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  sync_q, sync_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [3:0]  addrr_q, addrr_d;
    logic [3:0]  addrw_q, addrw_d;
    logic [31:0] data_out_q, data_out_d;
    logic        trigr_d, trigw_d;
    // power-up level only: any reset-driven change would itself be a bank access
    logic        trigr_q = 1'b0;
    logic        trigw_q = 1'b0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sync_d     = {sync_q[0], bus.readyIn};
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        addrr_d    = addrr_q;
        addrw_d    = addrw_q;
        data_out_d = data_out_q;
        trigr_d    = trigr_q;
        trigw_d    = trigw_q;
        case (state_q)
            S_IDLE: begin
                if (bus.wr_valid) begin
                    state_d    = S_WR_SETUP;
                    addrw_d    = bus.wr_addr;
                    data_out_d = bus.wr_data;
                end else if (bus.rd_valid) begin
                    state_d = S_RD_SETUP;
                    addrr_d = bus.rd_addr;
                end
            end
            S_WR_SETUP: begin
                trigw_d = ~trigw_q;
                cnt_d   = WR_HOLD_C;
                state_d = S_WR_HOLD;
            end
            S_WR_HOLD: begin
                cnt_d   = cnt_q - 5'd1;
                state_d = (cnt_q <= 5'd1) ? S_IDLE : S_WR_HOLD;
            end
            S_RD_SETUP: begin
                trigr_d = ~trigr_q;
                cnt_d   = RD_WAIT_C;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                cnt_d   = (cnt_q <= 5'd1) ? RD_TO_C : cnt_q - 5'd1;
                state_d = (cnt_q <= 5'd1) ? S_RD_DONE : S_RD_WAIT;
            end
            S_RD_DONE: begin
                if (sync_q[1]) begin
                    rsp_data_d = bus.dataIn;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RSP;
                end else if (cnt_q == 5'd0) begin
                    rsp_data_d = 32'd0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RSP;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            S_RSP:   state_d = bus.rsp_ready ? S_IDLE : S_RSP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 5'd0;
            sync_q     <= 2'd0;
            rsp_data_q <= 32'd0;
            rsp_err_q  <= 1'b0;
            addrr_q    <= 4'd0;
            addrw_q    <= 4'd0;
            data_out_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sync_q     <= sync_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            addrr_q    <= addrr_d;
            addrw_q    <= addrw_d;
            data_out_q <= data_out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            trigr_q <= trigr_d;
            trigw_q <= trigw_d;
        end
    end

    assign bus.wr_ready    = state_q == S_IDLE;
    assign bus.rd_ready    = (state_q == S_IDLE) && !bus.wr_valid;
    assign bus.rsp_valid   = state_q == S_RSP;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.triggerOutr = trigr_q;
    assign bus.triggerOutw = trigw_q;
    assign bus.addrr       = addrr_q;
    assign bus.addrw       = addrw_q;
    assign bus.dataOut     = data_out_q;
endmodule

// File: doc/regbank_initiator.md
# regbank_initiator

Clocked initiator for the register bank's two-phase (transition-signalled) read and write ports. Converts valid/ready read and write requests from the decoder and writeback stages into trigger toggles, address/data hold windows and ready-qualified data capture. It is the synchronous front end that drives the register bank's `triggerInr`/`triggerInw` side. Only one bank access is in flight at a time, and writes take priority over reads so a same-cycle read observes the write.

## Interface
- `WR_HOLD`, 2: cycles `addrw`/`dataOut` stay stable after the write toggle (min 1).
- `RD_WAIT`, 4: cycles after the read toggle before `readyIn` is sampled (min 2; covers the bank's readyOut low pulse plus the synchroniser).
- `RD_TIMEOUT`, 16: cycles in RD_DONE waiting for synchronised ready before an error response.
- `clk`  in  1  clock.
- `rstn`  in  1  synchronous reset, active-low.
- `rd_valid`  in  1  read request.
- `rd_ready`  out  1  read accepted when high with `rd_valid`.
- `rd_addr`  in  4  register index.
- `rsp_valid`  out  1  read response valid.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  32  read data.
- `rsp_err`  out  1  response is a timeout; `rsp_data`=0.
- `wr_valid`  in  1  write request.
- `wr_ready`  out  1  write accepted when high with `wr_valid`.
- `wr_addr`  in  4  register index.
- `wr_data`  in  32  write data.
- `triggerOutr`  out  1  read trigger; every edge is one read.
- `addrr`  out  4  bank read address.
- `readyIn`  in  1  bank readyOut; asynchronous; 2-flop synchronised to `ready_s`.
- `dataIn`  in  32  bank dataOut; sampled only when `ready_s`=1 in RD_DONE.
- `triggerOutw`  out  1  write trigger; every edge is one write.
- `addrw`  out  4  bank write address.
- `dataOut`  out  32  bank write data.

## Operation
- States: IDLE, WR_SETUP, WR_HOLD, RD_SETUP, RD_WAIT, RD_DONE, RSP.
- `wr_ready` = IDLE. `rd_ready` = IDLE & !`wr_valid`. This gives write priority.
- IDLE → WR_SETUP on write accept: latch `addrw`/`dataOut`.
- WR_SETUP → WR_HOLD: invert `triggerOutw`, load the counter with WR_HOLD.
- WR_HOLD → IDLE when the counter reaches 0.
- IDLE → RD_SETUP on read accept: latch `addrr`.
- RD_SETUP → RD_WAIT: invert `triggerOutr`, load the counter with RD_WAIT.
- RD_WAIT → RD_DONE when the counter reaches 0.
- RD_DONE:
  - If `ready_s`=1: capture `dataIn` → `rsp_data`, `rsp_err`=0, go to RSP.
  - After RD_TIMEOUT cycles without ready: `rsp_data`=0, `rsp_err`=1, go to RSP.
- RSP: `rsp_valid`=1 and `rsp_data`/`rsp_err` held stable until `rsp_ready`, then IDLE.
- The counter is 5 bits wide. Parameters above 31 are illegal.
- Address 15 (PC) is read and written like any other index. There is no special handling.
- Reset values: state IDLE, `rsp_valid` 0, `rsp_err` 0, `rsp_data` 0, `addrr` 0, `addrw` 0, `dataOut` 0, counters 0, sync flops 0.
- `triggerOutr`/`triggerOutw` are NOT changed by reset. A reset-forced level change would itself be a bank access. Both are initialised to 0 at power-up only.
- Reset mid-operation:
  - An in-flight read is abandoned with no response.
  - An in-flight write may already have been committed by the bank. This is acceptable.
  - No extra trigger edge is generated.

## Timing
- Cycle 0 = accept edge.
- Write: `addrw`/`dataOut` valid from cycle 1. `triggerOutw` edge at cycle 2; data is therefore stable for ≥1 cycle before the edge. Hold lasts cycles 2..1+WR_HOLD. `wr_ready` is high again at cycle 2+WR_HOLD (4 by default).
- Read:
  - `addrr` valid from cycle 1; `triggerOutr` edge at cycle 2.
  - RD_WAIT occupies cycles 2..1+RD_WAIT; RD_DONE starts at cycle 2+RD_WAIT.
  - Earliest `rsp_valid` is cycle 3+RD_WAIT (7 by default).
  - `rd_ready` is next high the cycle after the `rsp_valid`&`rsp_ready` handshake.
- Back-to-back: a new accept can occur on the cycle the FSM is in IDLE. There is no bubble beyond that.
- Same-cycle `wr_valid`+`rd_valid` in IDLE: the write is accepted. The read stays pending and is accepted at cycle 2+WR_HOLD. Its data reflects the write.
- Timeout: `rsp_err` response at cycle 3+RD_WAIT+RD_TIMEOUT if `ready_s` never rises.

## Test plan
- Write 0xDEADBEEF to r3, stub bank latches on `triggerOutw` edge → `addrw`=3, `dataOut`=0xDEADBEEF stable cycles 1–3; edge at cycle 2; `wr_ready` high at cycle 4.
- Read r3 from a bank model with a 1 ns readyOut low pulse returning 0xDEADBEEF → `triggerOutr` toggles once; `rsp_valid` at cycle 7 with `rsp_data`=0xDEADBEEF, `rsp_err`=0.
- Same-cycle write r5=0x12345678 and read r5 → write edge first; read accepted at cycle 4; response 0x12345678.
- Bank model holding `readyIn`=0 → `rsp_valid` at cycle 23 with `rsp_err`=1, `rsp_data`=0. Hold `rsp_ready`=0 for 5 cycles → outputs stable, no new accept.
- Two consecutive reads of r1 and r15 → exactly two `triggerOutr` edges (0→1, 1→0); responses in order.
- Assert `rstn`=0 during RD_WAIT → no `rsp_valid`; `triggerOutr` level unchanged; `rd_ready` high the cycle after reset release.
